// File: rtl/mmio_mem_v2.sv
// Unified program RAM / tile map / frame buffer / IO block for the 16-bit CPU:
// two 2-cycle read ports, one write port, tile display pipeline and UART TX FIFO.
module mmio_mem_v2 #(
  parameter logic [15:0] TILEMAP_START     = 16'hC000,
  parameter logic [15:0] FRAMEBUFFER_START = 16'hE000,
  parameter logic [15:0] IO_START          = 16'hF000,
  parameter int          TILE_LOG2         = 3,
  parameter int          FB_COLS_LOG2      = 7,
  parameter int          FB_ROWS_LOG2      = 6,
  parameter int          TX_FIFO_LOG2      = 3,
  parameter              PROGRAM_FILE      = "../data/program.hex",
  parameter              TILEMAP_FILE      = "../data/tilemap.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] raddr0,
  output logic [15:0] rdata0,
  input  logic        ren,
  input  logic [15:0] raddr1,
  output logic [15:0] rdata1,
  input  logic        wen,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  output logic        ps2_ren,
  input  logic [15:0] ps2_data_in,
  input  logic [9:0]  pixel_x_in,
  input  logic [9:0]  pixel_y_in,
  output logic [11:0] pixel,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int RAM_WORDS = int'(TILEMAP_START);
  localparam int RAM_AW    = $clog2(RAM_WORDS);
  localparam int TM_WORDS  = int'(FRAMEBUFFER_START) - int'(TILEMAP_START);
  localparam int TM_AW     = $clog2(TM_WORDS);
  localparam int FB_AW     = FB_COLS_LOG2 + FB_ROWS_LOG2 - 1;
  localparam int SX_W      = FB_COLS_LOG2 + TILE_LOG2;
  localparam int SY_W      = FB_ROWS_LOG2 + TILE_LOG2;
  localparam int TIDX_W    = 8 + 2 * TILE_LOG2;
  localparam int DEPTH     = 1 << TX_FIFO_LOG2;
  localparam logic [TX_FIFO_LOG2:0] FULL_CNT = DEPTH[TX_FIFO_LOG2:0];

  localparam logic [15:0] A_PS2     = 16'hFFFF;
  localparam logic [15:0] A_VSCROLL = 16'hFFFE;
  localparam logic [15:0] A_HSCROLL = 16'hFFFD;
  localparam logic [15:0] A_SCALE   = 16'hFFFC;
  localparam logic [15:0] A_STATUS  = 16'hF001;
  localparam logic [15:0] A_TX      = 16'hF000;

  typedef enum logic [1:0] {R_RAM, R_TMAP, R_FB, R_IO} region_t;

  function automatic region_t region_of(input logic [15:0] a);
    if (a < TILEMAP_START) return R_RAM;
    if (a < FRAMEBUFFER_START) return R_TMAP;
    if (a < IO_START) return R_FB;
    return R_IO;
  endfunction

  function automatic logic [15:0] io_rd(input logic [15:0] a, input logic [15:0] ps2,
                                        input logic [15:0] vs, input logic [15:0] hs,
                                        input logic [1:0] sc, input logic [15:0] st);
    case (a)
      A_PS2:     return ps2;
      A_VSCROLL: return vs;
      A_HSCROLL: return hs;
      A_SCALE:   return {14'd0, sc};
      A_STATUS:  return st;
      default:   return 16'd0;
    endcase
  endfunction

  logic [15:0] ram  [RAM_WORDS];
  logic [15:0] tmap [TM_WORDS];
  logic [15:0] fb   [1 << FB_AW];
  logic [7:0]  fifo [DEPTH];

  logic [15:0] vscroll, hscroll;
  logic [1:0]  scale;
  logic [TX_FIFO_LOG2-1:0] rd_ptr, wr_ptr;
  logic [TX_FIFO_LOG2:0]   count;
  logic        overflow;
  logic        push, pop, full, do_push;
  logic [31:0] count_w;
  logic [3:0]  count_sat;
  logic [15:0] status;
  logic [7:0]  head_next;

  assign push          = wen && (waddr == A_TX);
  assign uart_tx_valid = (count != '0);
  assign pop           = uart_tx_valid && uart_tx_ready;
  assign full          = (count == FULL_CNT);
  assign do_push       = push && (!full || pop);
  assign count_w       = 32'(count);
  assign count_sat     = (count_w > 32'd15) ? 4'hF : count_w[3:0];
  assign status        = {8'h00, count_sat, 1'b0, overflow, full, !uart_tx_valid};

  // Head register keeps the last byte shown once the FIFO runs dry.
  always_comb begin
    head_next = uart_tx_data;
    if (pop) begin
      if (count > 1) head_next = fifo[rd_ptr + 1'b1];
      else if (push) head_next = wdata[7:0];
    end else if (!uart_tx_valid && push) begin
      head_next = wdata[7:0];
    end
  end

  // Memory arrays: no reset, contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wen) begin
      case (region_of(waddr))
        R_RAM:   ram[RAM_AW'(waddr)] <= wdata;
        R_TMAP:  tmap[TM_AW'(waddr - TILEMAP_START)] <= wdata;
        R_FB:    fb[FB_AW'(waddr - FRAMEBUFFER_START)] <= wdata;
        default: ;
      endcase
    end
    if (do_push) fifo[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vscroll      <= '0;
      hscroll      <= '0;
      scale        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      if (wen && waddr == A_VSCROLL) vscroll <= wdata;
      if (wen && waddr == A_HSCROLL) hscroll <= wdata;
      if (wen && waddr == A_SCALE)   scale   <= wdata[1:0];
      if (push && full && !pop)           overflow <= 1'b1;
      else if (wen && waddr == A_STATUS)  overflow <= 1'b0;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      uart_tx_data <= head_next;
    end
  end

  // Read ports: array read at the sampling edge (read-before-write), then output register.
  logic [15:0] rd0_c, rd1_c, rd0_q, rd1_q;

  always_comb begin
    rd0_c = '0;
    case (region_of(raddr0))
      R_RAM:   rd0_c = ram[RAM_AW'(raddr0)];
      R_TMAP:  rd0_c = tmap[TM_AW'(raddr0 - TILEMAP_START)];
      R_FB:    rd0_c = fb[FB_AW'(raddr0 - FRAMEBUFFER_START)];
      default: rd0_c = io_rd(raddr0, ps2_data_in, vscroll, hscroll, scale, status);
    endcase
  end

  always_comb begin
    rd1_c = '0;
    case (region_of(raddr1))
      R_RAM:   rd1_c = ram[RAM_AW'(raddr1)];
      R_TMAP:  rd1_c = tmap[TM_AW'(raddr1 - TILEMAP_START)];
      R_FB:    rd1_c = fb[FB_AW'(raddr1 - FRAMEBUFFER_START)];
      default: rd1_c = io_rd(raddr1, ps2_data_in, vscroll, hscroll, scale, status);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_q   <= '0;
      rd1_q   <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      ps2_ren <= 1'b0;
    end else begin
      rd0_q   <= rd0_c;
      rd1_q   <= rd1_c;
      rdata0  <= rd0_q;
      rdata1  <= rd1_q;
      ps2_ren <= ren && (raddr1 == A_PS2);
    end
  end

  // Display: stage A scales/scrolls and fetches the frame-buffer word, stage B the tile pixel.
  logic [9:0]          xs, ys;
  logic [SX_W-1:0]     sx;
  logic [SY_W-1:0]     sy;
  logic [FB_AW:0]      slot;
  logic [15:0]         fb_word_q;
  logic                odd_q;
  logic [TILE_LOG2-1:0] fx_q, fy_q;
  logic [7:0]          tile;
  logic [TIDX_W-1:0]   tidx;

  assign xs   = pixel_x_in >> scale;
  assign ys   = pixel_y_in >> scale;
  assign sx   = SX_W'(xs + hscroll[9:0]);
  assign sy   = SY_W'(ys + vscroll[9:0]);
  assign slot = {sy[SY_W-1:TILE_LOG2], sx[SX_W-1:TILE_LOG2]};
  assign tile = odd_q ? fb_word_q[15:8] : fb_word_q[7:0];
  assign tidx = {tile, fy_q, fx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_word_q <= '0;
      odd_q     <= 1'b0;
      fx_q      <= '0;
      fy_q      <= '0;
      pixel     <= '0;
    end else begin
      fb_word_q <= fb[slot[FB_AW:1]];
      odd_q     <= slot[0];
      fx_q      <= sx[TILE_LOG2-1:0];
      fy_q      <= sy[TILE_LOG2-1:0];
      pixel     <= tmap[TM_AW'(tidx)][11:0];
    end
  end

endmodule

// File: tb/tb_mmio_mem_v2.sv
// Directed and randomized bench for mmio_mem_v2 against a behavioural model
// of the address map, FIFO and tile display.
module tb_mmio_mem_v2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] raddr0, rdata0, raddr1, rdata1, waddr, wdata, ps2_data_in;
  logic        ren, wen, ps2_ren, uart_tx_valid, uart_tx_ready;
  logic [9:0]  pixel_x_in, pixel_y_in;
  logic [11:0] pixel;
  logic [7:0]  uart_tx_data;

  always #5 clk = ~clk;

  mmio_mem_v2 dut (
    .clk(clk), .rst_n(rst_n), .raddr0(raddr0), .rdata0(rdata0), .ren(ren),
    .raddr1(raddr1), .rdata1(rdata1), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ps2_ren(ps2_ren), .ps2_data_in(ps2_data_in), .pixel_x_in(pixel_x_in),
    .pixel_y_in(pixel_y_in), .pixel(pixel), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] mdl [int];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    step();
    wen = 1'b0;
    mdl[int'(a)] = d;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    raddr0 = a; raddr1 = a;
    step();
    step();
    check({tag, "_p0"}, rdata0, exp);
    check({tag, "_p1"}, rdata1, exp);
  endtask

  function automatic int play_x(int x, int sc, int hs);
    return ((x >> sc) + (hs % 1024)) % 1024;
  endfunction
  function automatic int play_y(int y, int sc, int vs);
    return ((y >> sc) + (vs % 1024)) % 512;
  endfunction
  function automatic int fb_addr(int sx, int sy);
    return 'hE000 + ((sy / 8) * 128 + sx / 8) / 2;
  endfunction
  function automatic int tm_addr(int sx, int sy);
    int slot, tile;
    logic [15:0] w;
    slot = (sy / 8) * 128 + sx / 8;
    w = mdl[fb_addr(sx, sy)];
    tile = (slot % 2 == 1) ? int'(w[15:8]) : int'(w[7:0]);
    return 'hC000 + tile * 64 + (sy % 8) * 8 + (sx % 8);
  endfunction
  function automatic logic [15:0] model_pixel(int x, int y, int sc, int hs, int vs);
    logic [15:0] w;
    w = mdl[tm_addr(play_x(x, sc, hs), play_y(y, sc, vs))];
    return {4'h0, w[11:0]};
  endfunction

  function automatic logic [15:0] fifo_status(int size, bit ovf);
    int c;
    c = (size > 15) ? 15 : size;
    return 16'((c << 4) | (int'(ovf) << 2) | (int'(size == 8) << 1) | int'(size == 0));
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  exp_head;
    bit          ovf;
    logic [15:0] e0_prev, e1_prev, st_m1, st_m2;

    rst_n = 1'b0; raddr0 = '0; raddr1 = '0; ren = 1'b0; wen = 1'b0; waddr = '0;
    wdata = '0; ps2_data_in = '0; pixel_x_in = '0; pixel_y_in = '0; uart_tx_ready = 1'b0;
    e0_prev = '0; e1_prev = '0; st_m1 = '0; st_m2 = '0;
    #12;
    check("rst_rdata0", rdata0, 16'h0);
    check("rst_rdata1", rdata1, 16'h0);
    check("rst_pixel", {4'h0, pixel}, 16'h0);
    check("rst_ps2_ren", {15'h0, ps2_ren}, 16'h0);
    check("rst_valid", {15'h0, uart_tx_valid}, 16'h0);
    check("rst_txdata", {8'h0, uart_tx_data}, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    rd_check("status_idle", 16'hF001, 16'h0001);

    wr(16'h0010, 16'h1234);
    rd_check("ram_rw", 16'h0010, 16'h1234);
    wen = 1'b1; waddr = 16'h0010; wdata = 16'h5678; raddr0 = 16'h0010;
    step();
    wen = 1'b0; mdl['h10] = 16'h5678;
    step();
    check("rbw_old", rdata0, 16'h1234);
    step();
    check("rbw_new", rdata0, 16'h5678);

    ps2_data_in = 16'h00AB; ren = 1'b1; raddr1 = 16'hFFFF; raddr0 = 16'h0;
    step();
    check("ps2_pulse", {15'h0, ps2_ren}, 16'h1);
    ren = 1'b0; raddr1 = 16'h0;
    step();
    check("ps2_pulse_end", {15'h0, ps2_ren}, 16'h0);
    check("ps2_data_p1", rdata1, 16'h00AB);
    ren = 1'b1; raddr0 = 16'hFFFF;
    step();
    check("ps2_p0_nopulse", {15'h0, ps2_ren}, 16'h0);
    ren = 1'b0; raddr0 = 16'h0;
    step();
    check("ps2_data_p0", rdata0, 16'h00AB);

    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(16'hF000, 16'(i));
    rd_check("status_full", 16'hF001, 16'h0086);
    uart_tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", {15'h0, uart_tx_valid}, 16'h1);
      check("drain_data", {8'h0, uart_tx_data}, 16'(i));
      step();
    end
    uart_tx_ready = 1'b0;
    check("drained_valid", {15'h0, uart_tx_valid}, 16'h0);
    check("drained_hold", {8'h0, uart_tx_data}, 16'h0008);
    wr(16'hF001, 16'h0);
    rd_check("ovf_clear", 16'hF001, 16'h0001);

    wr(16'hE000, 16'h0201); wr(16'hC040, 16'h0F00); wr(16'hC080, 16'h00F0);
    wr(16'hFFFC, 16'h0); wr(16'hFFFE, 16'h0); wr(16'hFFFD, 16'h8);
    pixel_x_in = 10'd0; pixel_y_in = 10'd0;
    step(); step();
    check("hscroll8", {4'h0, pixel}, 16'h00F0);
    wr(16'hC041, 16'h0ABC); wr(16'hFFFD, 16'h0); wr(16'hFFFC, 16'h1);
    pixel_x_in = 10'd2;
    step(); step();
    check("scale1", {4'h0, pixel}, 16'h0ABC);
    pixel_x_in = 10'd0;
    wen = 1'b1; waddr = 16'hFFFD; wdata = 16'h8;
    step();
    wen = 1'b0;
    step();
    check("scroll_same_edge", {4'h0, pixel}, 16'h0F00);
    step();
    check("scroll_next_edge", {4'h0, pixel}, 16'h00F0);
    wr(16'hFFFC, 16'hFFFF);
    rd_check("scale_rd", 16'hFFFC, 16'h0003);

    for (int a = 'h100; a < 'h140; a++) wr(16'(a), 16'($urandom));
    for (int t = 0; t < 150; t++) begin
      logic [15:0] a0, a1, wa, wd;
      logic [15:0] e0, e1;
      bit we;
      a0 = 16'('h100 + $urandom_range(63)); a1 = 16'('h100 + $urandom_range(63));
      wa = 16'('h100 + $urandom_range(63)); wd = 16'($urandom); we = 1'($urandom);
      e0 = mdl[int'(a0)]; e1 = mdl[int'(a1)];
      raddr0 = a0; raddr1 = a1; wen = we; waddr = wa; wdata = wd;
      step();
      if (we) mdl[int'(wa)] = wd;
      if (t > 0) begin
        check("rand_p0", rdata0, e0_prev);
        check("rand_p1", rdata1, e1_prev);
      end
      e0_prev = e0; e1_prev = e1;
    end
    wen = 1'b0;

    exp_head = 8'h08; ovf = 1'b0; raddr1 = 16'hF001;
    for (int t = 0; t < 200; t++) begin
      int op;
      bit rdy, popped;
      logic [7:0] b;
      logic [15:0] st;
      check("fifo_valid", {15'h0, uart_tx_valid}, {15'h0, q.size() > 0});
      check("fifo_data", {8'h0, uart_tx_data}, {8'h0, (q.size() > 0) ? q[0] : exp_head});
      if (q.size() > 0) exp_head = q[0];
      st = fifo_status(q.size(), ovf);
      if (t >= 2) check("fifo_status", rdata1, st_m2);
      st_m2 = st_m1; st_m1 = st;
      op = int'($urandom_range(7)); rdy = ($urandom_range(3) == 0); b = 8'($urandom);
      popped = rdy && (q.size() > 0);
      wen = (op <= 5); waddr = (op == 0) ? 16'hF001 : 16'hF000; wdata = {8'h0, b};
      uart_tx_ready = rdy;
      step();
      if (popped) void'(q.pop_front());
      if (op == 0) ovf = 1'b0;
      else if (op <= 5) begin
        if (q.size() < 8) q.push_back(b);
        else ovf = 1'b1;
      end
    end
    wen = 1'b0; uart_tx_ready = 1'b1;
    repeat (10) step();
    uart_tx_ready = 1'b0; q.delete();
    check("fifo_emptied", {15'h0, uart_tx_valid}, 16'h0);
    wr(16'hF001, 16'h0);

    for (int t = 0; t < 20; t++) begin
      int x, y, sc, hs, vs, sx, sy;
      x = int'($urandom_range(639)); y = int'($urandom_range(479));
      sc = int'($urandom_range(3)); hs = int'($urandom_range(16'hFFFF));
      vs = int'($urandom_range(16'hFFFF));
      wr(16'hFFFC, 16'(sc)); wr(16'hFFFD, 16'(hs)); wr(16'hFFFE, 16'(vs));
      sx = play_x(x, sc, hs); sy = play_y(y, sc, vs);
      wr(16'(fb_addr(sx, sy)), {1'b0, 7'($urandom), 1'b0, 7'($urandom)});
      wr(16'(tm_addr(sx, sy)), 16'($urandom));
      pixel_x_in = 10'(x); pixel_y_in = 10'(y);
      step(); step();
      check("rand_pixel", {4'h0, pixel}, model_pixel(x, y, sc, hs, vs));
    end

    wr(16'hF000, 16'h11); wr(16'hF000, 16'h22); wr(16'hF000, 16'h33);
    check("pre_rst_valid", {15'h0, uart_tx_valid}, 16'h1);
    check("pre_rst_head", {8'h0, uart_tx_data}, 16'h0011);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {15'h0, uart_tx_valid}, 16'h0);
    check("async_rst_txdata", {8'h0, uart_tx_data}, 16'h0);
    check("async_rst_pixel", {4'h0, pixel}, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    rd_check("status_after_rst", 16'hF001, 16'h0001);
    rd_check("hscroll_after_rst", 16'hFFFD, 16'h0000);
    rd_check("ram_survives_rst", 16'h0010, mdl['h10]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
